// File: rtl/matrix_chain_mult.sv
// Sequential fixed-point matrix-chain multiplier built around one MAC unit.
// Computes A*B, (A*B)*C, (A*B)*A^T or A*B^T on NxN signed Q-format matrices.
// Build option: define MATRIX_CHAIN_SAT_EN to clamp out-of-range elements;
// otherwise they wrap to the low WIDTH bits. ovf is reported in both builds.
module matrix_chain_mult #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N         = 4,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clk_en_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [N*N*WIDTH-1:0]   a_i,
  input  logic [N*N*WIDTH-1:0]   b_i,
  input  logic [N*N*WIDTH-1:0]   c_i,
  output logic [N*N*WIDTH-1:0]   res_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   ovf_o
);

  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned AccW  = 2 * WIDTH + $clog2(N);
  localparam logic [AccW-1:0] Half = AccW'(1) << (FRAC_BITS - 1);

  typedef logic [WIDTH-1:0] elem_t;
  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  state_e              state_q;
  logic [1:0]          mode_q;
  elem_t               a_q [N][N];
  elem_t               b_q [N][N];
  elem_t               c_q [N][N];
  elem_t               t_q [N][N];
  elem_t               w_q [N][N];
  elem_t               w_d [N][N];
  logic [IW-1:0]       i_q, j_q, k_q;
  logic [AccW-1:0]     acc_q;
  logic [N*N*WIDTH-1:0] res_q, res_d;
  logic                busy_q, done_q, ovf_q;

  elem_t               l_op, r_op;
  logic [ProdW-1:0]    prod;
  logic [AccW-1:0]     acc_sum, rnd;
  logic signed [AccW-1:0] r_val;
  logic [AccW-WIDTH:0] r_hi;
  logic                elem_ovf;
  elem_t               elem;
  logic                two_pass, last_k, last_elem, write_w;

  assign two_pass  = (mode_q == 2'd1) || (mode_q == 2'd2);
  assign last_k    = (k_q == IW'(N - 1));
  assign last_elem = last_k && (j_q == IW'(N - 1)) && (i_q == IW'(N - 1));
  assign write_w   = ((state_q == StPass1) && !two_pass) || (state_q == StPass2);

  // Operand selection: PASS1 uses A with B or B^T, PASS2 uses T with C or A^T.
  always_comb begin
    if (state_q == StPass2) begin
      l_op = t_q[i_q][k_q];
      r_op = (mode_q == 2'd1) ? c_q[k_q][j_q] : a_q[j_q][k_q];
    end else begin
      l_op = a_q[i_q][k_q];
      r_op = (mode_q == 2'd3) ? b_q[j_q][k_q] : b_q[k_q][j_q];
    end
  end

  // MAC, round-half-up, range check and element formatting.
  always_comb begin
    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    prod     = {{WIDTH{l_op[WIDTH-1]}}, l_op} * {{WIDTH{r_op[WIDTH-1]}}, r_op};
    acc_sum  = acc_q + {{(AccW - ProdW){prod[ProdW-1]}}, prod};
    rnd      = acc_sum + Half;
    r_val    = $signed(rnd) >>> FRAC_BITS;
    r_hi     = r_val[AccW-1:WIDTH-1];
    elem_ovf = (|r_hi) && !(&r_hi);
`ifdef MATRIX_CHAIN_SAT_EN
    if (elem_ovf) begin
      elem = r_val[AccW-1] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end else begin
      elem = r_val[WIDTH-1:0];
    end
`else
    elem = r_val[WIDTH-1:0];
`endif
  end

  // Work buffer with the current element merged in, so Res can load it on the last MAC.
  always_comb begin
    w_d = w_q;
    if (write_w && last_k) begin
      w_d[i_q][j_q] = elem;
    end
    res_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        res_d[(i*N+j)*WIDTH +: WIDTH] = w_d[i][j];
      end
    end
  end

  // Control FSM, counters, accumulator and all storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          c_q[i][j] <= '0;
          t_q[i][j] <= '0;
          w_q[i][j] <= '0;
        end
      end
    end else if (clk_en_i) begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            mode_q <= mode_i;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                a_q[i][j] <= a_i[(i*N+j)*WIDTH +: WIDTH];
                b_q[i][j] <= b_i[(i*N+j)*WIDTH +: WIDTH];
                c_q[i][j] <= c_i[(i*N+j)*WIDTH +: WIDTH];
              end
            end
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StPass1;
          end
        end
        StPass1, StPass2: begin
          w_q <= w_d;
          if (last_k) begin
            acc_q <= '0;
            k_q   <= '0;
            if (elem_ovf) begin
              ovf_q <= 1'b1;
            end
            if ((state_q == StPass1) && two_pass) begin
              t_q[i_q][j_q] <= elem;
            end
            if (j_q == IW'(N - 1)) begin
              j_q <= '0;
              i_q <= (i_q == IW'(N - 1)) ? '0 : i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= acc_sum;
            k_q   <= k_q + 1'b1;
          end
          if (last_elem) begin
            if ((state_q == StPass1) && two_pass) begin
              state_q <= StPass2;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              res_q   <= res_d;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res_o  = res_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_matrix_chain_mult.sv
// Self-checking bench for matrix_chain_mult: directed and random operations
// compared against a plain-arithmetic matrix model.
module tb_matrix_chain_mult;

  localparam int unsigned W   = 16;
  localparam int unsigned N   = 4;
  localparam int unsigned F   = 8;
  localparam int unsigned NNW = N * N * W;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  logic           clk, rst, clk_en, start;
  logic [1:0]     mode;
  logic [NNW-1:0] a_in, b_in, c_in, res;
  logic           busy, done, ovf;

  int ma [N][N];
  int mb [N][N];
  int mc [N][N];
  int exp_res [N][N];
  bit exp_ovf;

  int checks   = 0;
  int failures = 0;

  matrix_chain_mult #(.WIDTH(W), .N(N), .FRAC_BITS(F)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clk_en_i (clk_en),
    .start_i  (start),
    .mode_i   (mode),
    .a_i      (a_in),
    .b_i      (b_in),
    .c_i      (c_in),
    .res_o    (res),
    .busy_o   (busy),
    .done_o   (done),
    .ovf_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Round-half-up to Q format, then range handling of one element.
  task automatic fix_elem(input longint acc, output int v);
    longint r;
    r = (acc + (longint'(1) << (F - 1))) >>> F;
    if (r > MAXV || r < MINV) begin
      exp_ovf = 1'b1;
`ifdef MATRIX_CHAIN_SAT_EN
      v = (r > 0) ? int'(MAXV) : int'(MINV);
`else
      v = int'($signed(r[W-1:0]));
`endif
    end else begin
      v = int'(r);
    end
  endtask

  task automatic model(input logic [1:0] md);
    int t [N][N];
    longint acc;
    int rv;
    exp_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          rv = (md == 2'd3) ? mb[j][k] : mb[k][j];
          acc += longint'(ma[i][k]) * longint'(rv);
        end
        fix_elem(acc, t[i][j]);
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (md == 2'd1 || md == 2'd2) begin
          acc = 0;
          for (int k = 0; k < N; k++) begin
            rv = (md == 2'd1) ? mc[k][j] : ma[j][k];
            acc += longint'(t[i][k]) * longint'(rv);
          end
          fix_elem(acc, exp_res[i][j]);
        end else begin
          exp_res[i][j] = t[i][j];
        end
      end
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in[(i*N+j)*W +: W] = 16'(ma[i][j]);
        b_in[(i*N+j)*W +: W] = 16'(mb[i][j]);
        c_in[(i*N+j)*W +: W] = 16'(mc[i][j]);
      end
    end
  endtask

  task automatic fill_rand(input bit big);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (big) begin
          ma[i][j] = int'($signed(16'($urandom)));
          mb[i][j] = int'($signed(16'($urandom)));
          mc[i][j] = int'($signed(16'($urandom)));
        end else begin
          ma[i][j] = int'($urandom_range(0, 1023)) - 512;
          mb[i][j] = int'($urandom_range(0, 1023)) - 512;
          mc[i][j] = int'($urandom_range(0, 1023)) - 512;
        end
      end
    end
  endtask

  task automatic set_all(input int va, input int vb, input int vc);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = va;
        mb[i][j] = vb;
        mc[i][j] = vc;
      end
    end
  endtask

  task automatic check_res(input string tag);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("%s_res%0d%0d", tag, i, j),
              longint'($signed(res[(i*N+j)*W +: W])), longint'(exp_res[i][j]));
      end
    end
  endtask

  // One full operation from IDLE; half_en drives clk_en at 50% duty, disturb
  // changes inputs and pulses start while busy.
  task automatic run_op(input logic [1:0] md, input bit half_en, input bit disturb,
                        input string tag);
    int lat, cnt;
    logic [NNW-1:0] prev_res;
    lat = (md == 2'd1 || md == 2'd2) ? 2 * N * N * N : N * N * N;
    if (half_en) lat = 2 * lat;
    model(md);
    pack();
    prev_res = res;
    mode   = md;
    start  = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, longint'(busy), 1);
    cnt = 0;
    while (done !== 1'b1 && cnt < 4 * lat) begin
      if (cnt == lat - 1) check({tag, "_res_hold"}, longint'(res == prev_res), 1);
      clk_en = half_en ? ((cnt + 1) % 2 == 0) : 1'b1;
      if (disturb && cnt == 5) begin
        a_in  = ~a_in;
        mode  = ~md;
        start = 1'b1;
      end
      if (disturb && cnt == 7) start = 1'b0;
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, cnt, lat);
    check({tag, "_done"}, longint'(done), 1);
    check({tag, "_busy_done"}, longint'(busy), 1);
    check({tag, "_ovf"}, longint'(ovf), longint'(exp_ovf));
    check_res(tag);
    if (half_en) begin
      clk_en = 1'b0;
      @(negedge clk);
      check({tag, "_done_stretch"}, longint'(done), 1);
    end
    clk_en = 1'b1;
    @(negedge clk);
    check({tag, "_done_fall"}, longint'(done), 0);
    check({tag, "_busy_fall"}, longint'(busy), 0);
    mode = md;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; start = 1'b0; mode = 2'd0;
    a_in = '0; b_in = '0; c_in = '0;
    #12;
    check("reset_res", longint'(|res), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_ovf", longint'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Identity times ramp, mode 0.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 32'h100 : 0;
        mb[i][j] = 32'h100 * (4 * i + j);
        mc[i][j] = 0;
      end
    run_op(2'd0, 1'b0, 1'b0, "ident");

    // Chain, mode 1: 2I * I * M.
    fill_rand(1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 32'h200 : 0;
        mb[i][j] = (i == j) ? 32'h100 : 0;
      end
    run_op(2'd1, 1'b0, 1'b0, "chain");

    // Transpose chain, mode 2.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 32'h100 * (i + 1) : 0;
        mb[i][j] = (i == j) ? 32'h100 : 0;
        mc[i][j] = 0;
      end
    run_op(2'd2, 1'b0, 1'b0, "transp");

    // Overflow, mode 0.
    set_all(32'h7FFF, 32'h7FFF, 0);
    run_op(2'd0, 1'b0, 1'b0, "ovf");

    // Handshake: half-rate enable, input changes and start while busy.
    fill_rand(1'b0);
    run_op(2'd0, 1'b1, 1'b1, "hshk");

    // Random operations.
    for (int n = 0; n < 8; n++) begin
      fill_rand($urandom_range(0, 3) == 0);
      run_op(2'($urandom_range(0, 3)), 1'b0, (n % 3) == 1, $sformatf("rand%0d", n));
    end

    // Asynchronous reset in the middle of PASS2.
    set_all(32'h7FFF, 32'h7FFF, 32'h0100);
    pack();
    mode = 2'd1; start = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N * N * N + 10) @(negedge clk);
    check("pre_rst_ovf", longint'(ovf), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_res", longint'(|res), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_ovf", longint'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_rand(1'b0);
    run_op(2'd3, 1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_chain_mult.md
# matrix_chain_mult

Sequential fixed-point matrix-chain multiplier for the filter datapath. It computes one of four products of N×N signed Q-format matrices (A·B, A·B·C, A·B·Aᵀ, A·B^T) with one multiply-accumulate unit. Operands are captured at start, so the host may change its inputs while the block is busy. It is the parametrised successor of the fixed two-pass three-matrix multiplier and adds operand latching, transpose modes, rounding, overflow reporting and a busy/done handshake.

## Interface
- WIDTH, 16: element width, signed two's complement.
- N, 4: matrix dimension, N ≥ 2.
- FRAC_BITS, 8: fractional bits of every operand and result, 1 ≤ FRAC_BITS < WIDTH.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  cycle enable; when low, all state, counters and outputs hold.
- start  in  1  request a new operation; sampled only in IDLE with clk_en=1.
- mode  in  2  0: A·B, 1: (A·B)·C, 2: (A·B)·Aᵀ, 3: A·Bᵀ.
- A, B, C  in  WIDTH × [N][N]  operand matrices.
- Res  out  WIDTH × [N][N]  result matrix, registered.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  high while in DONE.
- ovf  out  1  sticky per operation: some result element left the WIDTH range.

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE + start + clk_en:
  - Latch A, B, C and mode into internal registers.
  - Clear ovf, i, j, k and the accumulator.
  - Go to PASS1.
- Each enabled cycle in PASSx:
  - acc += L[i][k]·R'[k][j], where R' is R or Rᵀ per mode.
  - The full-precision accumulator is 2·WIDTH+clog2(N) bits wide.
  - k advances 0..N-1, then j, then i (row-major).
- When k = N-1, the element result is computed and stored at [i][j]:
  - r = (acc_final + 2^(FRAC_BITS-1)) >>> FRAC_BITS.
  - The accumulator clears for the next element.
- Pass operands:
  - PASS1 is L=A, R=B (Bᵀ in mode 3).
  - PASS2 is L=T, R=C (mode 1) or Aᵀ (mode 2). T is the internal buffer holding the PASS1 result.
- Routing:
  - Modes 0 and 3: PASS1 writes work buffer W, then go to DONE.
  - Modes 1 and 2: PASS1 writes T, then go to PASS2. PASS2 writes W, then go to DONE.
- Res ← W on the transition into DONE. Res never shows partial results.
- DONE:
  - done=1 and busy=1.
  - The next enabled cycle returns to IDLE.
  - start is ignored during DONE.
- start while busy is ignored. Latched operands are unaffected by input changes.
- If r is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], ovf is set. Element handling depends on the macro (see Configuration).
- rst, at any time including mid-pass, immediately forces:
  - State IDLE.
  - Res, T, W, counters and accumulator to 0.
  - busy=0, done=0, ovf=0.

## Timing
- Each pass takes N³ enabled cycles.
- Latency, counted from the accepting edge to the edge that raises done:
  - Modes 0 and 3: N³ enabled cycles.
  - Modes 1 and 2: 2·N³ enabled cycles.
  - For N=4 this is 64 and 128.
- done lasts one enabled cycle, so it stretches across clk_en-low cycles.
- A new start is accepted at the earliest on the enabled cycle after DONE.
- clk_en low freezes everything. Latency in clock cycles grows by the number of disabled cycles.

## Configuration
- MATRIX_CHAIN_SAT_EN defined: out-of-range elements clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
- MATRIX_CHAIN_SAT_EN undefined: out-of-range elements wrap, taking the low WIDTH bits of r.
- ovf behaves identically in both builds.

## Test plan
Defaults for all scenarios: WIDTH=16, N=4, FRAC_BITS=8, so 1.0 = 0x0100.
- Identity, mode 0:
  - Stimulus: A=I (0x0100 diagonal), B[i][j]=0x0100·(4i+j).
  - Response: Res=B, ovf=0. done rises exactly 64 enabled cycles after the accepting edge. busy falls one cycle after done.
- Chain, mode 1:
  - Stimulus: A=0x0200·I, B=I, C=M (arbitrary small values).
  - Response: Res=2·M. done at 128 cycles. Res unchanged until entering DONE.
- Transpose, mode 2:
  - Stimulus: A=diag(0x0100, 0x0200, 0x0300, 0x0400), B=I.
  - Response: Res=diag(0x0100, 0x0400, 0x0900, 0x1000).
- Overflow, mode 0:
  - Stimulus: A=B=all 0x7FFF.
  - Response: ovf=1. Res all 0x7FFF with the macro, all 0xFC00 without it.
- Handshake:
  - Stimulus: change A mid-operation; pulse start while busy; drive clk_en at 50% duty.
  - Response: result matches the latched operands; the second start is ignored; latency is 128 clocks for mode 0.
- Reset:
  - Stimulus: assert rst mid-PASS2 with no clock edge.
  - Response: Res=0, busy=0, done=0, ovf=0 immediately. A later start runs normally.
